// File: rtl/img_pkg.sv
// Shared types for the image ROM raster scanner: frame size defaults,
// scan FSM states and the pixel tag bundle carried through the output FIFO.
package img_pkg;

  localparam int DEF_IMG_WIDTH  = 160;
  localparam int DEF_IMG_HEIGHT = 120;
  localparam int CW             = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } scan_state_e;

  typedef struct packed {
    logic [7:0]    data;
    logic          eol;
    logic          eof;
`ifdef COORD_OUT_EN
    logic [CW-1:0] x;
    logic [CW-1:0] y;
`endif
  } pix_t;

endpackage

// File: rtl/pix_fifo2.sv
// 2-entry shift FIFO; slot0 is always the head so outputs come straight from flops.
// Ports: push_i/din_i in, pop_i in, flush_i clears, head_o/count_o out.
module pix_fifo2
  import img_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  pix_t       din_i,
  input  logic       pop_i,
  output pix_t       head_o,
  output logic [1:0] count_o
);

  logic [1:0] count_q;
  pix_t       s0_q;
  pix_t       s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      s0_q    <= '0;
      s1_q    <= '0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      if (push_i) begin
        if (count_q == 2'd0 || (count_q == 2'd1 && pop_i))
          s0_q <= din_i;
        else
          s1_q <= din_i;
      end
      if (pop_i && count_q == 2'd2)
        s0_q <= s1_q;
    end
  end

  assign head_o  = s0_q;
  assign count_o = count_q;

endmodule

// File: rtl/image_rom_scan_ctrl.sv
// Raster-order ROM read sequencer emitting a valid/ready pixel stream with eol/eof.
// Optional COORD_OUT_EN adds m_x/m_y outputs carried with each pixel.
module image_rom_scan_ctrl
  import img_pkg::*;
#(
  parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
  localparam int AW = $clog2(IMG_WIDTH * IMG_HEIGHT),
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [7:0]    m_data,
  output logic          m_eol,
  output logic          m_eof,
`ifdef COORD_OUT_EN
  output logic [XW-1:0] m_x,
  output logic [YW-1:0] m_y,
`endif
  output logic          busy,
  output logic          done
);

  scan_state_e   state_q;
  logic [AW-1:0] addr_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          infl_q;
  pix_t          tag_q;
  logic          busy_q;
  logic          done_q;

  pix_t          head;
  pix_t          push_pix;
  logic [1:0]    fcnt;
  logic [1:0]    occ;
  logic          pop;
  logic          issue;
  logic          flush;
  logic          x_last;
  logic          y_last;
  logic          last_px;

  assign m_valid = (fcnt != 2'd0);
  assign pop     = m_valid & m_ready;
  assign flush   = abort & (state_q != S_IDLE);

  // A pop this cycle frees a slot for the read issued this cycle.
  assign occ     = fcnt + {1'b0, infl_q} - {1'b0, pop};
  assign issue   = (state_q == S_RUN) & ~abort & (occ < 2'd2);

  assign x_last  = (x_q == XW'(IMG_WIDTH - 1));
  assign y_last  = (y_q == YW'(IMG_HEIGHT - 1));
  assign last_px = x_last & y_last;

  always_comb begin
    push_pix      = tag_q;
    push_pix.data = rom_data;
  end

  pix_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (infl_q),
    .din_i   (push_pix),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fcnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      infl_q  <= 1'b0;
      tag_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      infl_q <= issue;
      if (issue) begin
        tag_q.eol <= x_last;
        tag_q.eof <= last_px;
`ifdef COORD_OUT_EN
        tag_q.x   <= CW'(x_q);
        tag_q.y   <= CW'(y_q);
`endif
      end
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q <= S_RUN;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (issue) begin
            if (last_px) begin
              state_q <= S_DRAIN;
            end else begin
              addr_q <= addr_q + AW'(1);
              if (x_last) begin
                x_q <= '0;
                y_q <= y_q + YW'(1);
              end else begin
                x_q <= x_q + XW'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (pop && head.eof) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr = addr_q;
  assign m_data   = head.data;
  assign m_eol    = head.eol;
  assign m_eof    = head.eof;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef COORD_OUT_EN
  assign m_x      = head.x[XW-1:0];
  assign m_y      = head.y[YW-1:0];
`endif

endmodule

// File: tb/tb_image_rom_scan_ctrl.sv
// Directed bench for image_rom_scan_ctrl: a 4x3 instance for the protocol
// cases and a default 160x120 instance for the full-size frame.
module tb_image_rom_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_start = 0, s_abort = 0, s_ready = 0;
  logic [3:0] s_rom_addr;
  logic [7:0] s_rom_data = 0;
  logic       s_valid, s_eol, s_eof, s_busy, s_done;
  logic [7:0] s_data;
`ifdef COORD_OUT_EN
  logic [1:0] s_x, s_y;
`endif

  logic        b_start = 0, b_abort = 0, b_ready = 0;
  logic [14:0] b_rom_addr;
  logic [7:0]  b_rom_data = 0;
  logic        b_valid, b_eol, b_eof, b_busy, b_done;
  logic [7:0]  b_data;
`ifdef COORD_OUT_EN
  logic [7:0]  b_x;
  logic [6:0]  b_y;
`endif

  int n_assert = 0;
  int n_fail = 0;

  function automatic logic [7:0] fs(input int a);
    return 8'(a * 29 + 7);
  endfunction

  function automatic logic [7:0] fb(input int a);
    return 8'(a * 13 + (a >> 8));
  endfunction

  always @(posedge clk) s_rom_data <= fs(int'(s_rom_addr));
  always @(posedge clk) b_rom_data <= fb(int'(b_rom_addr));

  image_rom_scan_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .rom_addr(s_rom_addr), .rom_data(s_rom_data),
    .m_valid(s_valid), .m_ready(s_ready), .m_data(s_data),
    .m_eol(s_eol), .m_eof(s_eof),
`ifdef COORD_OUT_EN
    .m_x(s_x), .m_y(s_y),
`endif
    .busy(s_busy), .done(s_done)
  );

  image_rom_scan_ctrl u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data),
    .m_eol(b_eol), .m_eof(b_eof),
`ifdef COORD_OUT_EN
    .m_x(b_x), .m_y(b_y),
`endif
    .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_addr"}, 32'(s_rom_addr), 0);
    chk({tag, "_valid"}, 32'(s_valid), 0);
    chk({tag, "_data"}, 32'(s_data), 0);
    chk({tag, "_eol"}, 32'(s_eol), 0);
    chk({tag, "_eof"}, 32'(s_eof), 0);
    chk({tag, "_busy"}, 32'(s_busy), 0);
    chk({tag, "_done"}, 32'(s_done), 0);
  endtask

  task automatic pulse_start;
    s_start = 1;
    tick;
    s_start = 0;
  endtask

  // mode 0: m_ready held high; mode 1: m_ready random 50%
  task automatic run_small(input int mode);
    int idx = 0;
    int cyc = 1;
    int eof_cyc = -1;
    int first_v = -1;
    bit done_seen = 0;
    bit pstall = 0;
    logic [7:0] pd = 0;
    logic pl = 0, pf = 0;
    pulse_start;
    chk("start_busy", 32'(s_busy), 1);
    chk("start_addr", 32'(s_rom_addr), 0);
    while (!done_seen && cyc < 300) begin
      s_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (pstall) begin
        chk("stall_valid", 32'(s_valid), 1);
        chk("stall_data", 32'(s_data), 32'(pd));
        chk("stall_flags", {30'd0, s_eol, s_eof}, {30'd0, pl, pf});
      end
      if (s_valid && first_v < 0) first_v = cyc;
      chk("read_lead", 32'(int'(s_rom_addr) <= idx + 2), 1);
      if (s_done) begin
        done_seen = 1;
        chk("done_cycle", 32'(cyc), 32'(eof_cyc + 1));
        chk("done_busy", 32'(s_busy), 0);
        chk("pix_count", 32'(idx), 12);
      end else if (s_valid && s_ready) begin
        chk("no_extra", 32'(idx < 12), 1);
        chk("pix_data", 32'(s_data), 32'(fs(idx)));
        chk("pix_eol", 32'(s_eol), 32'(idx % 4 == 3));
        chk("pix_eof", 32'(s_eof), 32'(idx == 11));
`ifdef COORD_OUT_EN
        chk("pix_x", 32'(s_x), 32'(idx % 4));
        chk("pix_y", 32'(s_y), 32'(idx / 4));
`endif
        if (idx == 11) eof_cyc = cyc;
        idx++;
      end
      pstall = s_valid && !s_ready;
      pd = s_data;
      pl = s_eol;
      pf = s_eof;
      tick;
      cyc++;
    end
    chk("done_seen", 32'(done_seen), 1);
    chk("done_1cyc", 32'(s_done), 0);
    chk("idle_busy", 32'(s_busy), 0);
    if (mode == 0) begin
      chk("first_valid_cyc", 32'(first_v), 3);
      chk("frame_cycles", 32'(eof_cyc + 1), 15);
    end
    s_ready = 0;
  endtask

  initial begin
    #12;
    chk_reset_outs("reset");
    chk("big_reset_busy", 32'(b_busy), 0);
    @(negedge clk);
    rst_n = 1;
    tick;

    // 1: streaming frame, ready always high
    run_small(0);

    // 2: random backpressure
    run_small(1);
    run_small(1);

    // 3: stalled start then release
    s_ready = 0;
    pulse_start;
    repeat (20) tick;
    chk("stall_addr", 32'(s_rom_addr), 2);
    chk("stall_head_valid", 32'(s_valid), 1);
    chk("stall_head_data", 32'(s_data), 32'(fs(0)));
    for (int i = 0; i < 12; i++) begin
      s_ready = 1;
      chk("release_valid", 32'(s_valid), 1);
      chk("release_data", 32'(s_data), 32'(fs(i)));
      tick;
    end
    chk("release_done", 32'(s_done), 1);
    chk("release_busy", 32'(s_busy), 0);
    s_ready = 0;
    tick;

    // 4: abort with two pixels buffered
    begin
      int idx = 0;
      int guard = 0;
      pulse_start;
      while (idx < 5 && guard < 50) begin
        s_ready = 1;
        if (s_valid) idx++;
        tick;
        guard++;
      end
      chk("abort_setup", 32'(idx), 5);
      s_ready = 0;
      tick;
      tick;
      chk("abort_head_valid", 32'(s_valid), 1);
      chk("abort_head_data", 32'(s_data), 32'(fs(5)));
      s_abort = 1;
      tick;
      s_abort = 0;
      chk("abort_valid", 32'(s_valid), 0);
      chk("abort_busy", 32'(s_busy), 0);
      for (int i = 0; i < 4; i++) begin
        chk("abort_no_done", 32'(s_done), 0);
        tick;
      end
      run_small(0);
    end

    // 5: async reset mid-frame, start while busy, start+abort in idle
    s_ready = 1;
    pulse_start;
    repeat (6) tick;
    chk("prereset_valid", 32'(s_valid), 1);
    #3;
    rst_n = 0;
    #1;
    chk_reset_outs("midreset");
    @(negedge clk);
    rst_n = 1;
    tick;
    chk("postreset_busy", 32'(s_busy), 0);
    s_ready = 0;
    pulse_start;
    repeat (4) tick;
    pulse_start;
    tick;
    chk("busy_start_addr", 32'(s_rom_addr), 2);
    chk("busy_start_data", 32'(s_data), 32'(fs(0)));
    chk("busy_start_busy", 32'(s_busy), 1);
    s_abort = 1;
    tick;
    s_abort = 0;
    chk("abort2_busy", 32'(s_busy), 0);
    s_start = 1;
    s_abort = 1;
    tick;
    s_start = 0;
    s_abort = 0;
    chk("startabort_busy", 32'(s_busy), 0);
    tick;
    tick;
    chk("startabort_valid", 32'(s_valid), 0);
    chk("startabort_addr", 32'(s_rom_addr), 2);

    // 6: full-size frame
    begin
      int idx = 0;
      int cyc = 1;
      int done_cyc = -1;
      b_ready = 1;
      b_start = 1;
      tick;
      b_start = 0;
      while (done_cyc < 0 && cyc < 19400) begin
        if (b_done) begin
          done_cyc = cyc;
        end else if (b_valid) begin
          chk("big_data", 32'(b_data), 32'(fb(idx)));
          chk("big_eol", 32'(b_eol), 32'(idx % 160 == 159));
          chk("big_eof", 32'(b_eof), 32'(idx == 19199));
`ifdef COORD_OUT_EN
          chk("big_x", 32'(b_x), 32'(idx % 160));
          chk("big_y", 32'(b_y), 32'(idx / 160));
`endif
          idx++;
        end
        tick;
        cyc++;
      end
      chk("big_count", 32'(idx), 19200);
      chk("big_last_addr", 32'(b_rom_addr), 19199);
      chk("big_done_cyc", 32'(done_cyc), 19203);
      chk("big_busy", 32'(b_busy), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
